fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
// Instruction-fetch front end for the pipelined RV32I core; feeds the IF/ID register of the decode stage.
// Owns the fetch PC and issues pipelined requests to a variable-latency instruction memory.
// Buffers returned instructions in a prefetch FIFO and flushes cleanly on branch/jump redirects.
// PARAMETERS
// XLEN        32        address/PC width
// RESET_PC    32'h0     PC loaded on reset
// DEPTH       4         prefetch FIFO entries = max in-flight + buffered instructions (power of 2, >=2)
// PORTS
// clk             in   1     clock, all state on rising edge
// rst             in   1     asynchronous, active-low reset (rst==0 resets)
// imem_req_valid  out  1     fetch request valid
// imem_req_ready  in   1     memory accepts request
// imem_req_addr   out  XLEN  word-aligned fetch address
// imem_rsp_valid  in   1     instruction returned (in order, >=1 cycle after accept, no backpressure)
// imem_rsp_data   in   32    returned instruction
// redirect_valid  in   1     branch/jump taken from EX: flush and refetch
// redirect_pc     in   XLEN  redirect target; bits[1:0] forced to 0
// id_valid        out  1     instruction available to decode
// id_ready        in   1     decode accepts (low = stall)
// id_pc           out  XLEN  PC of id_instr
// id_instr        out  32    instruction to decode
// if_pc           out  XLEN  current fetch PC (debug/bench visibility)
// BEHAVIOUR
// Reset: if_pc=RESET_PC, resp_pc=RESET_PC, imem_req_valid=0, id_valid=0, FIFO empty, outstanding=0, drop_cnt=0.
// Counters outstanding, drop_cnt, fifo_count: $clog2(DEPTH+1) bits; PC arithmetic modulo 2^XLEN (wrap silently).
// Issue: imem_req_valid = !redirect_valid && (outstanding + fifo_count < DEPTH); addr = if_pc.
//   Accept (valid&&ready): outstanding+1, if_pc+=4. Addr held stable while valid and not accepted.
// Response: if drop_cnt>0 -> discard, drop_cnt-1; else push {resp_pc, data} into FIFO, resp_pc+=4.
//   Every response decrements outstanding. Credit rule guarantees no push into full FIFO (assert).
// Output: id_valid = FIFO non-empty && !redirect_valid; id_pc/id_instr = FIFO head (registered storage).
//   Pop on id_valid&&id_ready. Push and pop same cycle allowed at any occupancy, incl. full.
// Redirect cycle (redirect_valid=1), with priority over all other events:
//   no request issued; id_valid forced 0 (no pop); FIFO cleared;
//   if_pc<=resp_pc<={redirect_pc[XLEN-1:2],2'b00};
//   response arriving this cycle discarded; drop_cnt <= outstanding - imem_rsp_valid (all remaining in-flight dropped).
//   Back-to-back redirects: each recomputes drop_cnt from current outstanding; last target wins.
// First instruction reaches decode 2 cycles after reset release with 1-cycle memory (issue, respond/push, present).
// Reset mid-operation: all state cleared asynchronously; imem must share rst so no stale responses return.
// STRUCTURE
// riscv_pkg: XLEN, INSTR_W=32, NOP_INSTR=32'h0000_0013, fetch_entry_t struct {pc, instr}.
// Sub-module fetch_fifo: DEPTH-entry sync FIFO of fetch_entry_t with push/pop/flush, count, empty/full.
// Top holds if_pc, resp_pc, outstanding, drop_cnt and issue/redirect logic.
// TESTING
// 1. Reset release, 1-cycle memory, id_ready=1 -> id_pc 0,4,8,... one per cycle; addi x1=10,x2=20,add x3 -> x1=10,x2=20,x3=30.
// 2. id_ready=0 for 10 cycles -> exactly DEPTH(4) requests accepted, req_valid drops, no loss; release -> PCs continue in order.
// 3. imem_req_ready random 50%, 3-cycle latency -> id_pc strictly sequential, addr stable while unaccepted.
// 4. Redirect to 0x100 with 3 in flight -> 3 responses discarded, next id_pc=0x100, no stale PC ever presented.
// 5. Redirect coincident with response and with id_ready=1; then redirect_pc=0x203 -> id_valid=0 that cycle, next id_pc=0x200.
// 6. rst low mid-stream with FIFO full -> outputs at reset values immediately; refetch starts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Package  : riscv_pkg
// Purpose  : Shared widths, constants and the fetch-entry type of the RV32I core.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  // addi x0, x0, 0
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : DEPTH-entry synchronous FIFO of fetch entries with flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  fetch_entry_t                   push_data,
  input  logic                           pop,
  input  logic                           flush,
  output fetch_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty,
  output logic                           full
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign w_push_ok = push && !flush;
  assign w_pop_ok  = pop && !flush && !empty;

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; a simultaneous pop when full reads the old head first.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : RV32I fetch front end: PC, pipelined imem requests, prefetch FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;

  logic [CW-1:0]   w_fifo_count;
  logic            w_fifo_empty;
  logic            w_fifo_full;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;
  logic [CW:0]     w_credit_used;
  logic            w_credit_ok;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_drop;
  logic [XLEN-1:0] w_redirect_target;
  logic [CW-1:0]   w_remaining;

  // Every in-flight request owns a FIFO slot, so a response can always be stored.
  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign w_credit_ok   = (w_credit_used < (CW+1)'(DEPTH));

  // Gated by rst so the request line is quiet for the whole reset interval.
  assign imem_req_valid = rst && !redirect_valid && w_credit_ok;
  assign imem_req_addr  = r_if_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  assign w_drop = imem_rsp_valid && (r_drop_cnt != '0);
  assign w_push = imem_rsp_valid && !redirect_valid && (r_drop_cnt == '0);

  assign id_valid = !w_fifo_empty && !redirect_valid;
  assign w_pop    = id_valid && id_ready;
  assign id_pc    = w_head.pc;
  assign id_instr = w_head.instr;
  assign if_pc    = r_if_pc;

  assign w_redirect_target = redirect_pc & ~XLEN'(3);
  assign w_remaining       = r_outstanding - CW'(imem_rsp_valid);
  assign w_push_entry      = '{pc: r_resp_pc, instr: imem_rsp_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_pc       <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight belongs to the squashed path.
      r_if_pc       <= w_redirect_target;
      r_resp_pc     <= w_redirect_target;
      r_outstanding <= w_remaining;
      r_drop_cnt    <= w_remaining;
    end else begin
      if (w_accept) r_if_pc   <= r_if_pc + XLEN'(4);
      if (w_push)   r_resp_pc <= r_resp_pc + XLEN'(4);
      if (w_drop)   r_drop_cnt <= r_drop_cnt - CW'(1);
      case ({w_accept, imem_rsp_valid})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always @(posedge clk) begin
    if (rst) assert (!(w_push && w_fifo_full && !w_pop));
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .head      (w_head),
    .count     (w_fifo_count),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full)
  );

endmodule
`default_nettype wire
